// File: rtl/ray_dispatcher_if.sv
// rtl/ray_dispatcher_if.sv - upstream ray-job handshake between ray generator and dispatcher
interface ray_dispatcher_if #(
    parameter int POSITION_WIDTH = 16,
    parameter int ADDRESS_WIDTH  = 32
);
    logic                           start;
    logic                           ready;
    logic [2:0][POSITION_WIDTH-1:0] rayQ;
    logic [2:0][POSITION_WIDTH-1:0] rayV;
    logic [ADDRESS_WIDTH-1:0]       pixelAddress;

    modport master (output start, output rayQ, output rayV, output pixelAddress, input ready);
    modport slave  (input start, input rayQ, input rayV, input pixelAddress, output ready);
endinterface

// File: rtl/ray_dispatcher.sv
// rtl/ray_dispatcher.sv - N-way round-robin ray-job dispatcher with a job FIFO
module ray_dispatcher #(
    parameter int POSITION_WIDTH = 16,
    parameter int ADDRESS_WIDTH  = 32,
    parameter int NUM_UNITS      = 4,
    parameter int FIFO_DEPTH     = 4,
    parameter int COUNT_WIDTH    = 32
) (
    input  logic                           clock_i,
    input  logic                           reset_i,
    input  logic                           flush_i,
    ray_dispatcher_if.slave                job,
    output logic                           busy_o,
    input  logic [NUM_UNITS-1:0]           unitEnable_i,
    input  logic [NUM_UNITS-1:0]           unitReady_i,
    input  logic [NUM_UNITS-1:0]           unitBusy_i,
    output logic [NUM_UNITS-1:0]           unitStart_o,
    output logic [2:0][POSITION_WIDTH-1:0] unitRayQ_o,
    output logic [2:0][POSITION_WIDTH-1:0] unitRayV_o,
    output logic [ADDRESS_WIDTH-1:0]       unitPixelAddress_o,
    output logic [COUNT_WIDTH-1:0]         issuedCount_o
);
    localparam int PTR_W   = $clog2(FIFO_DEPTH);
    localparam int CNT_W   = PTR_W + 1;
    localparam int RR_W    = (NUM_UNITS > 1) ? $clog2(NUM_UNITS) : 1;
    localparam int ENTRY_W = 6 * POSITION_WIDTH + ADDRESS_WIDTH;

    logic [ENTRY_W-1:0]     mem_q [FIFO_DEPTH];
    logic [PTR_W-1:0]       wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]       count_q, count_d;
    logic [RR_W-1:0]        rr_ptr_q, rr_ptr_d;
    logic [COUNT_WIDTH-1:0] issued_q, issued_d;

    logic                   full, empty, accept, found, do_issue;
    logic [NUM_UNITS-1:0]   elig;
    logic [2*NUM_UNITS-1:0] elig_dbl;
    logic [RR_W-1:0]        offset, unit_k;
    logic [RR_W:0]          sum, nxt;

    assign full      = (count_q == CNT_W'(FIFO_DEPTH));
    assign empty     = (count_q == '0);
    assign job.ready = !full && !reset_i && !flush_i;
    assign accept    = job.start && job.ready;
    assign busy_o    = !empty || |(unitBusy_i & unitEnable_i);

    assign {unitRayQ_o, unitRayV_o, unitPixelAddress_o} = mem_q[rd_ptr_q];
    assign issuedCount_o = issued_q;

    // Rotating the doubled eligibility mask by rrPtr turns the wrap-around
    // search into a plain lowest-set-bit scan.
    assign elig     = unitReady_i & unitEnable_i;
    assign elig_dbl = {elig, elig} >> rr_ptr_q;

    always_comb begin
        found  = 1'b0;
        offset = '0;
        for (int i = 0; i < NUM_UNITS; i++) begin
            if (!found && elig_dbl[i]) begin
                found  = 1'b1;
                offset = RR_W'(i);
            end
        end
        sum = {1'b0, rr_ptr_q} + {1'b0, offset};
        if (sum >= (RR_W+1)'(NUM_UNITS)) begin
            sum = sum - (RR_W+1)'(NUM_UNITS);
        end
        unit_k = sum[RR_W-1:0];
        nxt    = {1'b0, unit_k} + (RR_W+1)'(1);
        if (nxt >= (RR_W+1)'(NUM_UNITS)) begin
            nxt = '0;
        end
    end

    assign do_issue    = !empty && !flush_i && !reset_i && found;
    assign unitStart_o = do_issue ? (NUM_UNITS'(1) << unit_k) : '0;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        rr_ptr_d = rr_ptr_q;
        issued_d = issued_q;
        if (flush_i) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (accept) begin
                wr_ptr_d = wr_ptr_q + PTR_W'(1);
            end
            if (do_issue) begin
                rd_ptr_d = rd_ptr_q + PTR_W'(1);
                rr_ptr_d = nxt[RR_W-1:0];
                issued_d = issued_q + COUNT_WIDTH'(1);
            end
            count_d = count_q + CNT_W'(accept) - CNT_W'(do_issue);
        end
    end

    always_ff @(posedge clock_i) begin
        if (reset_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            rr_ptr_q <= '0;
            issued_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            rr_ptr_q <= rr_ptr_d;
            issued_q <= issued_d;
        end
    end

    // Payload storage needs no reset; accept already excludes reset and flush.
    always_ff @(posedge clock_i) begin
        if (accept) begin
            mem_q[wr_ptr_q] <= {job.rayQ, job.rayV, job.pixelAddress};
        end
    end
endmodule

// File: tb/tb_ray_dispatcher.sv
// tb/tb_ray_dispatcher.sv - scoreboard testbench for ray_dispatcher
module tb_ray_dispatcher;
    localparam int PW = 16;
    localparam int AW = 32;
    localparam int N  = 4;
    localparam int D  = 4;
    localparam int CW = 32;

    typedef logic [2:0][PW-1:0] vec3_t;
    typedef struct packed {
        logic [N-1:0]  start;
        logic [AW-1:0] addr;
    } exp_t;

    logic          clock = 1'b0;
    logic          reset, flush, busy;
    logic [N-1:0]  en, rdy, ubusy, ustart;
    vec3_t         uq, uv;
    logic [AW-1:0] upa;
    logic [CW-1:0] icnt;

    exp_t sb[$];
    int   total = 0;
    int   bad   = 0;

    always #5 clock = ~clock;

    ray_dispatcher_if #(.POSITION_WIDTH(PW), .ADDRESS_WIDTH(AW)) job_if ();

    ray_dispatcher #(
        .POSITION_WIDTH(PW), .ADDRESS_WIDTH(AW), .NUM_UNITS(N),
        .FIFO_DEPTH(D), .COUNT_WIDTH(CW)
    ) dut (
        .clock_i(clock), .reset_i(reset), .flush_i(flush), .job(job_if.slave),
        .busy_o(busy), .unitEnable_i(en), .unitReady_i(rdy), .unitBusy_i(ubusy),
        .unitStart_o(ustart), .unitRayQ_o(uq), .unitRayV_o(uv),
        .unitPixelAddress_o(upa), .issuedCount_o(icnt)
    );

    function automatic vec3_t mk_q(input logic [AW-1:0] a);
        return {a[15:0] + 16'd2, a[15:0] + 16'd1, a[15:0]};
    endfunction

    function automatic vec3_t mk_v(input logic [AW-1:0] a);
        return {a[31:16], ~a[15:0], a[31:16] ^ 16'h5a5a};
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic drive_job(input logic [AW-1:0] a);
        job_if.start        = 1'b1;
        job_if.pixelAddress = a;
        job_if.rayQ         = mk_q(a);
        job_if.rayV         = mk_v(a);
    endtask

    task automatic send(input logic [AW-1:0] a, input logic [N-1:0] exp, input bit push);
        bit acc;
        drive_job(a);
        if (push) sb.push_back('{start: exp, addr: a});
        acc = 1'b0;
        for (int i = 0; i < 50 && !acc; i++) begin
            @(negedge clock);
            acc = job_if.ready;
            tick();
        end
        check("accept", acc, 1);
        job_if.start = 1'b0;
    endtask

    task automatic drain();
        for (int i = 0; i < 100 && sb.size() != 0; i++) tick();
        check("drain", sb.size(), 0);
    endtask

    // Monitor: every unitStart pulse must match the next scoreboard entry.
    initial begin
        exp_t e;
        forever begin
            @(negedge clock);
            if (!reset && ustart != '0) begin
                if (sb.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL unexpected_start: got %b expected none", ustart);
                end else begin
                    e = sb.pop_front();
                    check("unit_start", ustart, e.start);
                    check("pixel_addr", upa, e.addr);
                    check("ray_q", uq, mk_q(e.addr));
                    check("ray_v", uv, mk_v(e.addr));
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1, "timeout");
    end

    initial begin
        reset = 1'b1; flush = 1'b0;
        en = 4'b1111; rdy = 4'b1111; ubusy = '0;
        job_if.start = 1'b0; job_if.pixelAddress = '0;
        job_if.rayQ = '0; job_if.rayV = '0;
        repeat (2) tick();
        job_if.start = 1'b1;
        #1;
        check("rst_ready", job_if.ready, 0);
        check("rst_start", ustart, 0);
        tick();
        job_if.start = 1'b0;
        reset = 1'b0;
        #1;
        check("rst_icnt", icnt, 0);
        check("rst_busy", busy, 0);
        check("rst_ready_after", job_if.ready, 1);

        // 1: back-to-back round robin
        for (int i = 0; i < 4; i++) send(32'h1000 + i, N'(1) << i, 1);
        drain();
        check("t1_icnt", icnt, 4);
        check("t1_busy", busy, 0);

        // 2: units stalled, FIFO fills, fifth job held off
        rdy = 4'b0000;
        for (int i = 0; i < 4; i++) send(32'h2000 + i, N'(1) << i, 1);
        check("t2_ready_full", job_if.ready, 0);
        check("t2_busy", busy, 1);
        drive_job(32'h2004);
        sb.push_back('{start: 4'b0001, addr: 32'h2004});
        for (int i = 0; i < 3; i++) begin
            tick();
            check("t2_held", job_if.ready, 0);
        end
        check("t2_icnt_held", icnt, 4);
        rdy = 4'b1111;
        send(32'h2004, 4'b0001, 0);
        drain();
        check("t2_icnt", icnt, 9);

        // 3: wrap-around search from rrPtr=2
        send(32'h3000, 4'b0010, 1);
        drain();
        rdy = 4'b0011;
        send(32'h3001, 4'b0001, 1);
        drain();
        send(32'h3002, 4'b0010, 1);
        drain();
        rdy = 4'b1000;
        send(32'h3003, 4'b1000, 1);
        drain();
        check("t3_icnt", icnt, 13);

        // 4: enable mask restricts selection
        en = 4'b1010; rdy = 4'b1111;
        send(32'h4000, 4'b0010, 1);
        send(32'h4001, 4'b1000, 1);
        send(32'h4002, 4'b0010, 1);
        send(32'h4003, 4'b1000, 1);
        drain();
        check("t4_icnt", icnt, 17);
        ubusy = 4'b0001;
        #1;
        check("t4_busy_masked", busy, 0);
        ubusy = 4'b0010;
        #1;
        check("t4_busy_enabled", busy, 1);
        ubusy = '0; en = 4'b1111;

        // 5: flush drops queued jobs
        rdy = 4'b0000;
        for (int i = 0; i < 3; i++) send(32'h5000 + i, '0, 0);
        check("t5_busy_queued", busy, 1);
        tick();
        flush = 1'b1; rdy = 4'b1111;
        #1;
        check("t5_flush_ready", job_if.ready, 0);
        check("t5_flush_start", ustart, 0);
        tick();
        flush = 1'b0;
        #1;
        check("t5_ready_after", job_if.ready, 1);
        check("t5_busy_after", busy, 0);
        check("t5_icnt", icnt, 17);
        repeat (3) tick();

        // 6: full FIFO with a same-cycle pop does not accept
        rdy = 4'b0000;
        for (int i = 0; i < 4; i++) send(32'h6000 + i, N'(1) << i, 1);
        check("t6_full", job_if.ready, 0);
        drive_job(32'h6004);
        sb.push_back('{start: 4'b0001, addr: 32'h6004});
        rdy = 4'b0001;
        #1;
        check("t6_no_bypass", job_if.ready, 0);
        check("t6_issue", ustart, 4'b0001);
        tick();
        rdy = 4'b0000;
        #1;
        check("t6_count3_ready", job_if.ready, 1);
        tick();
        job_if.start = 1'b0;
        #1;
        check("t6_count4_full", job_if.ready, 0);
        rdy = 4'b1111;
        drain();
        check("t6_icnt", icnt, 22);
        check("t6_busy", busy, 0);

        check("sb_empty", sb.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
